pixel_prefetch: RTL and testbench

PIXEL_PREFETCH -- requirements
Module: pixel_prefetch

---
 rtl/pixel_prefetch_pkg.sv | 14 +
 rtl/pixel_prefetch_if.sv | 23 ++
 rtl/pixel_prefetch_fifo.sv | 53 +++++
 rtl/pixel_prefetch.sv | 109 ++++++++++
 tb/tb_pixel_prefetch.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_prefetch_pkg.sv
// Shared defaults and FSM state encoding for the pixel prefetch block.
package grayblast_pkg;

  localparam int PIX_W              = 4;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_FETCH_LAT  = 3;
  localparam int DEFAULT_RST_CYCLES = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RESET = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

endpackage

// File: rtl/pixel_prefetch_if.sv
// Consumer request/delivery signals plus the RP2040 framebuffer link.
interface pixel_prefetch_if;

  logic                            pix_req;
  logic [grayblast_pkg::PIX_W-1:0] pix_gray;
  logic                            pix_valid;
  logic                            frame_next_pixel_out;
  logic                            frame_reset_out;
  logic [grayblast_pkg::PIX_W-1:0] frame_pixel_in;

  // Consumer and RP2040 side: drives requests and pixel data.
  modport master (
    output pix_req, frame_pixel_in,
    input  pix_gray, pix_valid, frame_next_pixel_out, frame_reset_out
  );

  // Prefetcher side.
  modport slave (
    input  pix_req, frame_pixel_in,
    output pix_gray, pix_valid, frame_next_pixel_out, frame_reset_out
  );

endinterface

// File: rtl/pixel_prefetch_fifo.sv
// Small pixel FIFO with push, pop, flush and occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module pixel_fifo
  import grayblast_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PIX_W-1:0]         push_data,
  output logic [PIX_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_prefetch.sv
// Prefetches gray pixels from the RP2040 framebuffer into a small FIFO
// and hands them to the VGA consumer one per request.
module pixel_prefetch
  import grayblast_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int FETCH_LAT  = DEFAULT_FETCH_LAT,
  parameter int RST_CYCLES = DEFAULT_RST_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  pixel_prefetch_if.slave        bus,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int WCW = $clog2(FETCH_LAT + 1);

  logic [1:0]       state;
  logic [RCW-1:0]   rst_cnt;
  logic [WCW-1:0]   wait_cnt;
  logic             toggle;
  logic [PIX_W-1:0] gray_q;
  logic             valid_q;
  logic [PIX_W-1:0] head;
  logic             push;
  logic             pop;
  logic             fifo_has_room;

  assign fifo_has_room = (fill_level < CW'(DEPTH));
  assign push = (state == S_WAIT) && (wait_cnt == WCW'(1)) && !frame_start;
  assign pop  = bus.pix_req && !frame_start && (fill_level != '0);

  assign bus.pix_gray             = gray_q;
  assign bus.pix_valid            = valid_q;
  assign bus.frame_next_pixel_out = toggle;
  assign bus.frame_reset_out      = (state == S_RESET);

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (frame_start),
    .push      (push),
    .pop       (pop),
    .push_data (bus.frame_pixel_in),
    .head      (head),
    .count     (fill_level)
  );

  // Fetch sequencer: rewind pulse, then one outstanding fetch at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rst_cnt  <= '0;
      wait_cnt <= '0;
      toggle   <= 1'b0;
    end else if (frame_start) begin
      state    <= S_RESET;
      rst_cnt  <= RCW'(RST_CYCLES);
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RESET: begin
          rst_cnt <= rst_cnt - RCW'(1);
          if (rst_cnt == RCW'(1)) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (fifo_has_room) begin
            toggle   <= ~toggle;
            wait_cnt <= WCW'(FETCH_LAT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - WCW'(1);
          if (wait_cnt == WCW'(1)) state <= S_ISSUE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delivery to the consumer; an empty FIFO on request latches underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q    <= '0;
      valid_q   <= 1'b0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      valid_q   <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.pix_req) begin
      if (fill_level != '0) begin
        gray_q  <= head;
        valid_q <= 1'b1;
      end else begin
        gray_q    <= '0;
        valid_q   <= 1'b0;
        underflow <= 1'b1;
      end
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_prefetch.sv
// Testbench for pixel_prefetch: RP2040 responder plus a queue-based
// reference model of frame rewind, fetch timing and FIFO delivery.
module tb_pixel_prefetch;

  localparam int DEPTH      = 4;
  localparam int FETCH_LAT  = 3;
  localparam int RST_CYCLES = 2;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       underflow;
  logic [2:0] fill_level;

  pixel_prefetch_if bus();

  pixel_prefetch #(
    .DEPTH      (DEPTH),
    .FETCH_LAT  (FETCH_LAT),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .bus         (bus),
    .underflow   (underflow),
    .fill_level  (fill_level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  int mode;          // 0 idle, 1 rewinding, 2 fetching
  int reset_left;
  bit pending;
  int due;
  int cyc = 0;
  int next_pix;
  int exp_gray;
  bit exp_valid;
  bit exp_uf;
  bit exp_toggle;

  // RP2040 responder state
  int rp_ptr;
  bit rp_last;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RP2040 model: rewinds while frame_reset_out is high, advances one pixel per toggle
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_ptr = 0;
      rp_last = 1'b0;
      bus.frame_pixel_in = 4'd0;
    end else begin
      if (bus.frame_reset_out) rp_ptr = 0;
      if (bus.frame_next_pixel_out !== rp_last) begin
        rp_last = bus.frame_next_pixel_out;
        rp_ptr = rp_ptr + 1;
      end
      bus.frame_pixel_in = 4'(rp_ptr % 16);
    end
  end

  // Watchdog against an unexpected hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    q.delete();
    mode = 0;
    reset_left = 0;
    pending = 1'b0;
    next_pix = 1;
    exp_gray = 0;
    exp_valid = 1'b0;
    exp_uf = 1'b0;
    exp_toggle = 1'b0;
  endtask

  task automatic model_edge(input bit fs, input bit req);
    int size0;
    cyc++;
    size0 = q.size();
    if (fs) begin
      q.delete();
      pending = 1'b0;
      exp_uf = 1'b0;
      exp_valid = 1'b0;
      mode = 1;
      reset_left = RST_CYCLES;
      next_pix = 1;
    end else begin
      if (req) begin
        if (size0 > 0) begin
          exp_gray = q.pop_front();
          exp_valid = 1'b1;
        end else begin
          exp_gray = 0;
          exp_valid = 1'b0;
          exp_uf = 1'b1;
        end
      end else begin
        exp_valid = 1'b0;
      end
      if (mode == 1) begin
        reset_left--;
        if (reset_left == 0) mode = 2;
      end else if (mode == 2) begin
        if (pending) begin
          if (cyc == due) begin
            q.push_back(next_pix % 16);
            next_pix++;
            pending = 1'b0;
          end
        end else if (size0 < DEPTH) begin
          pending = 1'b1;
          due = cyc + FETCH_LAT;
          exp_toggle = ~exp_toggle;
        end
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check_val("fill_level", 32'(fill_level), 32'(q.size()));
    check_val("pix_valid", 32'(bus.pix_valid), 32'(exp_valid));
    check_val("pix_gray", 32'(bus.pix_gray), 32'(exp_gray));
    check_val("underflow", 32'(underflow), 32'(exp_uf));
    check_val("frame_reset_out", 32'(bus.frame_reset_out), 32'(mode == 1));
    check_val("frame_next_pixel_out", 32'(bus.frame_next_pixel_out), 32'(exp_toggle));
  endtask

  task automatic apply_stimulus(input bit fs, input bit req);
    frame_start = fs;
    bus.pix_req = req;
    @(posedge clk);
    model_edge(fs, req);
    #1;
    check_output();
    frame_start = 1'b0;
    bus.pix_req = 1'b0;
  endtask

  task automatic wait_fill(input int lvl, input bit need_pending, input string tag);
    int n = 0;
    while (!(q.size() == lvl && (!need_pending || pending)) && n < 100) begin
      apply_stimulus(1'b0, 1'b0);
      n++;
    end
    check_val(tag, 32'(n < 100), 32'd1);
  endtask

  initial begin
    int rate;
    rst_n = 1'b0;
    frame_start = 1'b0;
    bus.pix_req = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle holds without frame_start
    repeat (3) apply_stimulus(1'b0, 1'b0);

    // Frame start fills the FIFO with 1..4 and holds
    apply_stimulus(1'b1, 1'b0);
    repeat (25) apply_stimulus(1'b0, 1'b0);
    check_val("fill_full", 32'(fill_level), 32'd4);

    // Sparse requests drain in order with refill
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(1'b0, 1'b1);
      check_val("seq_gray", 32'(bus.pix_gray), 32'(k));
      repeat (7) apply_stimulus(1'b0, 1'b0);
    end

    // Request every cycle from frame start: underflow latches
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_val("first_req_underflow", 32'(underflow), 32'd1);
    repeat (20) apply_stimulus(1'b0, 1'b1);

    // Restart with fill 3 and a fetch in flight
    apply_stimulus(1'b1, 1'b0);
    wait_fill(3, 1'b1, "wait_fill3_pending");
    apply_stimulus(1'b1, 1'b0);
    check_val("restart_flush", 32'(fill_level), 32'd0);
    wait_fill(1, 1'b0, "wait_fill1");
    apply_stimulus(1'b0, 1'b1);
    check_val("restart_first_pix", 32'(bus.pix_gray), 32'd1);

    // frame_start beats a simultaneous request
    apply_stimulus(1'b1, 1'b0);
    wait_fill(2, 1'b0, "wait_fill2");
    apply_stimulus(1'b1, 1'b1);
    check_val("collide_valid", 32'(bus.pix_valid), 32'd0);
    check_val("collide_underflow", 32'(underflow), 32'd0);
    check_val("collide_fill", 32'(fill_level), 32'd0);

    // Randomized traffic with occasional frame restarts
    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      rate = (i < 200) ? 2 : 0;
      apply_stimulus($urandom_range(0, 99) == 0, $urandom_range(0, rate) == 0);
    end

    // Asynchronous reset while a fetch is outstanding
    apply_stimulus(1'b1, 1'b0);
    wait_fill(1, 1'b1, "wait_in_flight");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output();
    @(posedge clk);
    #1;
    check_output();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) apply_stimulus(1'b0, 1'b0);
    check_val("no_push_after_reset", 32'(fill_level), 32'd0);
    apply_stimulus(1'b1, 1'b0);
    repeat (12) apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_val("resume_first_pix", 32'(bus.pix_gray), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
